key_scan_ctrl: RTL and testbench

Controller that sits in front of the 32-bit key-entry shift buffer and sequences it. It scans a 4x4 active-low key matrix and debounces presses. For each accepted press it issues a one-cycle key_in/key_val strobe to the buffer and counts accepted digits. It converts a clear request into a single-cycle clear strobe and locks out further digits once the buffer holds MAX_DIGITS nibbles.

---
 rtl/key_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_key_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_ctrl.sv
// 4x4 key matrix scanner with debounce, digit counting/lockout and clear strobe generation.
// Optional: define KEYCTRL_FKEY_CLEAR_EN to make key 15 act as a clear request instead of a digit.
module key_scan_ctrl #(
  parameter int SCAN_DIV   = 1000,
  parameter int DB_CYCLES  = 20000,
  parameter int MAX_DIGITS = 8
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  input  logic       clear_req,
  output logic       key_in,
  output logic [3:0] key_val,
  output logic       clear,
  output logic [3:0] digits,
  output logic       full
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [19:0] DB_LAST    = 20'(DB_CYCLES - 1);
  localparam logic [3:0]  DIGITS_MAX = 4'(MAX_DIGITS);

  state_t      state_reg, state_next;
  logic [3:0]  col_meta_reg, col_sync_reg;
  logic [1:0]  row_reg, row_next;
  logic [1:0]  col_cap_reg, col_cap_next;
  logic [15:0] dwell_reg, dwell_next;
  logic [19:0] db_reg, db_next;
  logic        clear_req_reg;
  logic        key_in_reg, key_in_next;
  logic [3:0]  key_val_reg, key_val_next;
  logic        clear_reg, clear_next;
  logic [3:0]  digits_reg, digits_next;

  logic        clear_edge;
  logic        any_low;
  logic [1:0]  low_col;
  logic        fkey_hit;

  assign clear_edge = clear_req & ~clear_req_reg;
  assign any_low    = ~&col_sync_reg;

  // Lowest-index low column wins, so scan from the top down.
  always_comb begin
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_sync_reg[i]) low_col = 2'(i);
    end
  end

`ifdef KEYCTRL_FKEY_CLEAR_EN
  assign fkey_hit = (state_reg == EMIT) && ({row_reg, col_cap_reg} == 4'hF);
`else
  assign fkey_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= SCAN;
      col_meta_reg  <= 4'hF;
      col_sync_reg  <= 4'hF;
      row_reg       <= 2'd0;
      col_cap_reg   <= 2'd0;
      dwell_reg     <= '0;
      db_reg        <= '0;
      clear_req_reg <= 1'b0;
      key_in_reg    <= 1'b0;
      key_val_reg   <= 4'd0;
      clear_reg     <= 1'b0;
      digits_reg    <= 4'd0;
    end else begin
      state_reg     <= state_next;
      col_meta_reg  <= col_n;
      col_sync_reg  <= col_meta_reg;
      row_reg       <= row_next;
      col_cap_reg   <= col_cap_next;
      dwell_reg     <= dwell_next;
      db_reg        <= db_next;
      clear_req_reg <= clear_req;
      key_in_reg    <= key_in_next;
      key_val_reg   <= key_val_next;
      clear_reg     <= clear_next;
      digits_reg    <= digits_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    col_cap_next = col_cap_reg;
    dwell_next   = dwell_reg;
    db_next      = db_reg;
    key_in_next  = 1'b0;
    key_val_next = key_val_reg;
    clear_next   = 1'b0;
    digits_next  = digits_reg;

    case (state_reg)
      SCAN: begin
        if (dwell_reg == DWELL_LAST) begin
          dwell_next = '0;
          if (any_low) begin
            col_cap_next = low_col;
            db_next      = '0;
            state_next   = DEBOUNCE;
          end else begin
            row_next = row_reg + 2'd1;
          end
        end else begin
          dwell_next = dwell_reg + 16'd1;
        end
      end
      DEBOUNCE: begin
        if (col_sync_reg[col_cap_reg]) begin
          dwell_next = '0;
          state_next = SCAN;
        end else if (db_reg == DB_LAST) begin
          state_next = EMIT;
        end else begin
          db_next = db_reg + 20'd1;
        end
      end
      EMIT: begin
        db_next    = '0;
        state_next = RELEASE;
        if (!full && !fkey_hit) begin
          key_in_next  = 1'b1;
          key_val_next = {row_reg, col_cap_reg};
          digits_next  = digits_reg + 4'd1;
        end
      end
      RELEASE: begin
        if (any_low) begin
          db_next = '0;
        end else if (db_reg == DB_LAST) begin
          dwell_next = '0;
          row_next   = row_reg + 2'd1;
          state_next = SCAN;
        end else begin
          db_next = db_reg + 20'd1;
        end
      end
      default: state_next = SCAN;
    endcase

    // A clear discards any digit being emitted in the same cycle.
    if (clear_edge || fkey_hit) begin
      clear_next   = 1'b1;
      key_in_next  = 1'b0;
      key_val_next = key_val_reg;
      digits_next  = 4'd0;
    end
  end

  assign row_n   = ~(4'b0001 << row_reg);
  assign key_in  = key_in_reg;
  assign key_val = key_val_reg;
  assign clear   = clear_reg;
  assign digits  = digits_reg;
  assign full    = (digits_reg == DIGITS_MAX);

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Scoreboard bench for key_scan_ctrl: a keypad model drives col_n, a digit-count model predicts
// every key/clear strobe, and a negedge monitor pops and compares each strobe the DUT produces.
module tb_key_scan_ctrl;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int MD = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       clear_req = 1'b0;
  logic       key_in;
  logic [3:0] key_val;
  logic       clear;
  logic [3:0] digits;
  logic       full;

  logic [15:0] pressed = '0;

  typedef struct {
    bit         is_clear;
    logic [3:0] val;
    logic [3:0] dig;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  kcyc[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  model_digits = 0;
  int  cyc = 0;

  key_scan_ctrl #(.SCAN_DIV(SD), .DB_CYCLES(DB), .MAX_DIGITS(MD)) dut (
    .clock(clock), .reset(reset), .row_n(row_n), .col_n(col_n), .clear_req(clear_req),
    .key_in(key_in), .key_val(key_val), .clear(clear), .digits(digits), .full(full)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_clear();
    ev_t e;
    model_digits = 0;
    e.is_clear = 1'b1; e.val = 4'd0; e.dig = 4'd0;
    exp_q.push_back(e);
  endtask

  task automatic expect_key(input int k);
    ev_t e;
`ifdef KEYCTRL_FKEY_CLEAR_EN
    if (k == 15) begin
      expect_clear();
      return;
    end
`endif
    if (model_digits < MD) begin
      model_digits++;
      e.is_clear = 1'b0; e.val = 4'(k); e.dig = 4'(model_digits);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && (key_in || clear)) begin
      if (key_in) kcyc.push_back(cyc);
      check("strobe_exclusive", {31'd0, key_in & clear}, 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: got key_in=%0d clear=%0d key_val=%0d, required none",
                 key_in, clear, key_val);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_clear) begin
          check("clear_strobe", {31'd0, clear}, 32'd1);
          check("clear_digits", {28'd0, digits}, 32'd0);
          check("clear_full", {31'd0, full}, 32'd0);
          $display("t=%0t clear digits=%0d", $time, digits);
        end else begin
          check("key_strobe", {31'd0, key_in}, 32'd1);
          check("key_val", {28'd0, key_val}, {28'd0, mon_e.val});
          check("key_digits", {28'd0, digits}, {28'd0, mon_e.dig});
          check("key_full", {31'd0, full}, (mon_e.dig == 4'(MD)) ? 32'd1 : 32'd0);
          $display("t=%0t key val=%0d digits=%0d", $time, key_val, digits);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    pressed = '0;
    clear_req = 1'b0;
    #1;
    check("rst_row_n", {28'd0, row_n}, 32'hE);
    check("rst_key_in", {31'd0, key_in}, 32'd0);
    check("rst_clear", {31'd0, clear}, 32'd0);
    check("rst_digits", {28'd0, digits}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    tick(2);
    reset = 1'b1;
  endtask

  task automatic press(input logic [15:0] m, input int hold, input int rel);
    pressed = m;
    tick(hold);
    pressed = '0;
    tick(rel);
  endtask

  task automatic pulse_clear(input int len);
    clear_req = 1'b1;
    tick(len);
    clear_req = 1'b0;
    tick(2);
  endtask

  // Fixed stimulus after reset: key 0 pressed twice; optional clear_req rise at offset clr_off.
  task automatic sched(input int clr_off, output int off2);
    int s;
    do_reset();
    kcyc.delete();
    s = cyc;
    for (int k = 0; k < 170; k++) begin
      pressed   = ((k < 50) || (k >= 80 && k < 130)) ? 16'h0001 : 16'h0000;
      clear_req = (clr_off >= 0 && k >= clr_off && k < clr_off + 3);
      tick(1);
    end
    pressed = '0;
    clear_req = 1'b0;
    off2 = (kcyc.size() >= 2) ? kcyc[1] - s : -1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int off2, dummy, sel, k, r, c1, c2;
    logic [3:0] exp_row;

    do_reset();
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      exp_row = ~(4'b0001 << ((i / SD) % 4));
      check("row_cycle", {28'd0, row_n}, {28'd0, exp_row});
    end
    // Key 0 gets into debounce, then reset aborts it before any strobe.
    pressed = 16'h0001;
    tick(20);
    do_reset();
    model_digits = 0;

    expect_key(9);
    press(16'h0200, 40, 16);
    expect_clear();
    pulse_clear(10);
    for (int kk = 1; kk <= 9; kk++) begin
      expect_key(kk);
      press(16'(1) << kk, 40, 16);
    end
    check("lock_digits", {28'd0, digits}, MD);
    check("lock_full", {31'd0, full}, 32'd1);
    expect_clear();
    pulse_clear(10);
    check("clr_digits", {28'd0, digits}, 32'd0);
    check("clr_full", {31'd0, full}, 32'd0);
    expect_key(1);
    press(16'h000A, 40, 16);
    expect_key(15);
    press(16'h8000, 40, 16);

    // Clear edge landing on the emit cycle of the second press.
    model_digits = 0;
    expect_key(0);
    expect_key(0);
    sched(-1, off2);
    if (off2 < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL calibrate: got %0d strobes, required 2", kcyc.size());
      exp_q.delete();
    end else begin
      model_digits = 0;
      expect_key(0);
      expect_clear();
      sched(off2 - 1, dummy);
      check("align_digits", {28'd0, digits}, 32'd0);
    end
    model_digits = int'(digits);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        k = $urandom_range(0, 15);
        expect_key(k);
        press(16'(1) << k, 40 + $urandom_range(0, 20), 16 + $urandom_range(0, 8));
      end else if (sel == 6) begin
        r  = $urandom_range(0, 3);
        c1 = $urandom_range(0, 2);
        c2 = $urandom_range(c1 + 1, 3);
        expect_key(4 * r + c1);
        press((16'(1) << (4 * r + c1)) | (16'(1) << (4 * r + c2)), 45, 16);
      end else if (sel == 7) begin
        k = $urandom_range(0, 15);
        press(16'(1) << k, $urandom_range(1, 3), 12);
      end else begin
        expect_clear();
        pulse_clear($urandom_range(1, 10));
      end
    end

    tick(4);
    check("pending_events", exp_q.size(), 32'd0);
    check("final_digits", {28'd0, digits}, model_digits);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
